// File: rtl/light_ctrl_pkg.sv
// Shared types for the lighting sequencer: FSM state encoding, button events
// and the output decode helpers used by light_mode_controller.
package light_ctrl_pkg;

    typedef enum logic [2:0] {
        AUTO_OFF   = 3'd0,
        AUTO_ON    = 3'd1,
        AUTO_HOLD  = 3'd2,
        MANUAL_OFF = 3'd3,
        MANUAL_ON  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        EVT_NONE  = 2'd0,
        EVT_SHORT = 2'd1,
        EVT_LONG  = 2'd2
    } press_evt_t;

    function automatic logic state_lamp(input state_t s);
        return (s == AUTO_ON) || (s == MANUAL_ON);
    endfunction

    function automatic logic state_manual(input state_t s);
        return (s == MANUAL_OFF) || (s == MANUAL_ON);
    endfunction

endpackage

// File: rtl/press_classifier.sv
// Measures how long the debounced button is held and emits a registered
// one-cycle EVT_SHORT on release or EVT_LONG when the hold reaches LONG_PRESS_T.
module press_classifier
    import light_ctrl_pkg::*;
#(
    parameter int LONG_PRESS_T = 3000,
    parameter int MIN_PRESS_T  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_i,
    output press_evt_t evt_o
);

    localparam int CW      = $clog2(LONG_PRESS_T + 1);
    // A minimum above the long threshold can never yield a short press.
    localparam int MIN_SAT = (MIN_PRESS_T > LONG_PRESS_T) ? LONG_PRESS_T : MIN_PRESS_T;
    localparam logic [CW-1:0] LONG_C    = CW'(LONG_PRESS_T);
    localparam logic [CW-1:0] LONG_M1_C = CW'(LONG_PRESS_T - 1);
    localparam logic [CW-1:0] MIN_C     = CW'(MIN_SAT);

    logic [CW-1:0] press_cnt_q, press_cnt_d;
    press_evt_t    evt_q, evt_d;

    // Next hold count and the event it produces at this edge.
    always_comb begin
        press_cnt_d = press_cnt_q;
        evt_d       = EVT_NONE;
        if (button_i) begin
            if (press_cnt_q != LONG_C) begin
                press_cnt_d = press_cnt_q + CW'(1);
                if (press_cnt_q == LONG_M1_C) begin
                    evt_d = EVT_LONG;
                end else begin
                    evt_d = EVT_NONE;
                end
            end else begin
                press_cnt_d = press_cnt_q;
                evt_d       = EVT_NONE;
            end
        end else begin
            press_cnt_d = '0;
            if ((press_cnt_q >= MIN_C) && (press_cnt_q < LONG_C)) begin
                evt_d = EVT_SHORT;
            end else begin
                evt_d = EVT_NONE;
            end
        end
    end

    // Counter and event registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_cnt_q <= '0;
            evt_q       <= EVT_NONE;
        end else begin
            press_cnt_q <= press_cnt_d;
            evt_q       <= evt_d;
        end
    end

    assign evt_o = evt_q;

endmodule

// File: rtl/light_mode_controller.sv
// Lighting sequencer: automatic (presence-driven) vs manual mode selection.
// Define LIGHT_CTRL_HOLDOFF_EN to build the post-shutdown infrared holdoff.
module light_mode_controller
    import light_ctrl_pkg::*;
#(
    parameter int LONG_PRESS_T = 3000,
    parameter int MIN_PRESS_T  = 10,
    parameter int HOLDOFF_T    = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_button,
    input  logic infravermelho,
    input  logic shutdown,
    output logic lamp,
    output logic mode_manual,
    output logic timer_rst
);

    press_evt_t evt_s;
    state_t     state_q, state_d;
    logic       lamp_q, mode_manual_q, timer_rst_q;

    press_classifier #(
        .LONG_PRESS_T (LONG_PRESS_T),
        .MIN_PRESS_T  (MIN_PRESS_T)
    ) u_press_classifier (
        .clk      (clk),
        .rst_n    (rst_n),
        .button_i (push_button),
        .evt_o    (evt_s)
    );

`ifdef LIGHT_CTRL_HOLDOFF_EN
    localparam int HCW = $clog2(HOLDOFF_T + 1);
    localparam logic [HCW-1:0] HOLD_LAST_C = HCW'(HOLDOFF_T - 1);
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
`else
    // HOLDOFF_T has no effect in this build.
    if (HOLDOFF_T < 0) begin : g_holdoff_unused
    end
`endif

    // Next-state logic; long press outranks short press, which outranks sensors.
    always_comb begin
        state_d = state_q;
`ifdef LIGHT_CTRL_HOLDOFF_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            AUTO_OFF: begin
                if (evt_s == EVT_LONG) begin
                    state_d = MANUAL_OFF;
                end else if (infravermelho) begin
                    state_d = AUTO_ON;
                end else begin
                    state_d = AUTO_OFF;
                end
            end
            AUTO_ON: begin
                if (evt_s == EVT_LONG) begin
                    state_d = MANUAL_ON;
                end else if (shutdown) begin
`ifdef LIGHT_CTRL_HOLDOFF_EN
                    state_d    = AUTO_HOLD;
                    hold_cnt_d = '0;
`else
                    state_d = AUTO_OFF;
`endif
                end else begin
                    state_d = AUTO_ON;
                end
            end
`ifdef LIGHT_CTRL_HOLDOFF_EN
            AUTO_HOLD: begin
                if (evt_s == EVT_LONG) begin
                    state_d = MANUAL_OFF;
                end else if (hold_cnt_q == HOLD_LAST_C) begin
                    state_d = AUTO_OFF;
                end else begin
                    state_d    = AUTO_HOLD;
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
`endif
            MANUAL_OFF: begin
                if (evt_s == EVT_LONG) begin
                    state_d = AUTO_OFF;
                end else if (evt_s == EVT_SHORT) begin
                    state_d = MANUAL_ON;
                end else begin
                    state_d = MANUAL_OFF;
                end
            end
            MANUAL_ON: begin
                if (evt_s == EVT_LONG) begin
                    state_d = AUTO_OFF;
                end else if (evt_s == EVT_SHORT) begin
                    state_d = MANUAL_OFF;
                end else begin
                    state_d = MANUAL_ON;
                end
            end
            default: begin
                state_d = AUTO_OFF;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they track it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= AUTO_OFF;
            lamp_q        <= 1'b0;
            mode_manual_q <= 1'b0;
            timer_rst_q   <= 1'b1;
`ifdef LIGHT_CTRL_HOLDOFF_EN
            hold_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            lamp_q        <= state_lamp(state_d);
            mode_manual_q <= state_manual(state_d);
            timer_rst_q   <= (state_d != AUTO_ON);
`ifdef LIGHT_CTRL_HOLDOFF_EN
            hold_cnt_q    <= hold_cnt_d;
`endif
        end
    end

    assign lamp        = lamp_q;
    assign mode_manual = mode_manual_q;
    assign timer_rst   = timer_rst_q;

endmodule
